// File: rtl/crc32_rx_checker.sv
// Receive-side CRC-32 checker: strips the 4-byte FCS, forwards payload, reports status per frame.
// Optional CRC32_RX_ERRCNT_EN adds a saturating err_cnt port counting failed frames.
module crc32_rx_checker #(
  parameter int unsigned LEN_W    = 16,
  parameter logic [31:0] CRC_INIT = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             s_ready,
  output logic             m_valid,
  output logic [7:0]       m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic             chk_valid,
  output logic             chk_ok,
  output logic             chk_runt,
  output logic [LEN_W-1:0] frame_len
`ifdef CRC32_RX_ERRCNT_EN
  ,
  output logic [15:0]      err_cnt
`endif
);

  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  // MSB-first byte update of the LFSR, no reflection
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[31] ^ d[i]) r = (r << 1) ^ POLY;
      else              r = r << 1;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {IDLE, FILL, PASS, REPORT} state_t;

  state_t          state, state_nxt;
  logic [3:0][7:0] dl;
  logic [2:0]      fill;
  logic [31:0]     lfsr;
  logic [LEN_W-1:0] len;

  logic             accept;
  logic [31:0]      crc_nxt;
  logic [31:0]      fcs_rx;
  logic [LEN_W-1:0] len_inc;

  assign s_ready = !rst && (state != REPORT) && (!m_valid || m_ready);
  assign accept  = s_valid && s_ready;
  assign crc_nxt = crc_byte(lfsr, dl[3]);
  assign fcs_rx  = {s_data, dl[0], dl[1], dl[2]};
  assign len_inc = (&len) ? len : len + LEN_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = s_last ? REPORT : FILL;
      FILL: begin
        if (accept) begin
          if (s_last)              state_nxt = REPORT;
          else if (fill == 3'd3)   state_nxt = PASS;
        end
      end
      PASS:    if (accept && s_last) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Delay line, CRC, length and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl        <= '0;
      fill      <= 3'd0;
      lfsr      <= CRC_INIT;
      len       <= '0;
      m_valid   <= 1'b0;
      m_data    <= 8'd0;
      m_last    <= 1'b0;
      chk_valid <= 1'b0;
      chk_ok    <= 1'b0;
      chk_runt  <= 1'b0;
      frame_len <= '0;
    end else begin
      chk_valid <= 1'b0;
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
      if (accept) begin
        dl <= {dl[2:0], s_data};
        case (state)
          IDLE: begin
            lfsr <= CRC_INIT;
            fill <= 3'd1;
            len  <= '0;
          end
          FILL: fill <= fill + 3'd1;
          PASS: begin
            m_valid <= 1'b1;
            m_data  <= dl[3];
            m_last  <= s_last;
            lfsr    <= crc_nxt;
            len     <= len_inc;
          end
          default: ;
        endcase
        if (s_last) begin
          chk_valid <= 1'b1;
          if (state == PASS) begin
            chk_ok    <= (crc_nxt == fcs_rx);
            chk_runt  <= 1'b0;
            frame_len <= len_inc;
          end else begin
            chk_ok    <= 1'b0;
            chk_runt  <= 1'b1;
            frame_len <= '0;
          end
        end
      end
    end
  end

`ifdef CRC32_RX_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                 err_cnt <= 16'd0;
    else if (chk_valid && !chk_ok && (err_cnt != 16'hFFFF))  err_cnt <= err_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_crc32_rx_checker.sv
// Scoreboard bench for crc32_rx_checker: table-driven CRC model, queued expectations, decoupled monitor.
`timescale 1ns/1ps
module tb_crc32_rx_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_last, s_ready;
  logic [7:0]  s_data;
  logic        m_valid, m_last, m_ready;
  logic [7:0]  m_data;
  logic        chk_valid, chk_ok, chk_runt;
  logic [15:0] frame_len;
`ifdef CRC32_RX_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  crc32_rx_checker dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .chk_valid(chk_valid), .chk_ok(chk_ok), .chk_runt(chk_runt), .frame_len(frame_len)
`ifdef CRC32_RX_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int err_model = 0;
  int rdy_mode = 0;   // 0: always ready, 1: toggle, 2: random
  int gap_pct = 0;

  logic [31:0] crc_tbl [256];
  logic [8:0]  exp_data_q [$];   // {last, data}
  logic [17:0] exp_stat_q [$];   // {ok, runt, len}

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_crc(input logic [7:0] q [$]);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (q[i]) c = (c << 8) ^ crc_tbl[c[31:24] ^ q[i]];
    return c;
  endfunction

  // Frame-level expectation: payload is all but the trailing 4 FCS bytes (LSB first)
  task automatic push_expect(input logic [7:0] f [$]);
    int n = f.size();
    logic [7:0]  pl [$];
    logic [31:0] fcs;
    logic        ok;
    if (n >= 5) begin
      for (int i = 0; i < n - 4; i++) pl.push_back(f[i]);
      foreach (pl[i]) exp_data_q.push_back({(i == pl.size() - 1) ? 1'b1 : 1'b0, pl[i]});
      fcs = {f[n-1], f[n-2], f[n-3], f[n-4]};
      ok = (model_crc(pl) == fcs);
      exp_stat_q.push_back({ok, 1'b0, 16'((n - 4 > 65535) ? 65535 : n - 4)});
      if (!ok) err_model++;
    end else begin
      exp_stat_q.push_back({1'b0, 1'b1, 16'd0});
      err_model++;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int t = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      t++;
      if (t > 2000) begin
        chk("s_ready_timeout", 64'(t), 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    if ($urandom_range(0, 99) < gap_pct) begin
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic send_frame(input logic [7:0] f [$], input bit push);
    if (push) push_expect(f);
    foreach (f[i]) send_byte(f[i], i == f.size() - 1);
  endtask

  task automatic make_good(input int plen, output logic [7:0] f [$]);
    logic [31:0] c;
    f = {};
    for (int i = 0; i < plen; i++) f.push_back(8'($urandom));
    c = model_crc(f);
    f.push_back(c[7:0]); f.push_back(c[15:8]); f.push_back(c[23:16]); f.push_back(c[31:24]);
  endtask

  task automatic drain;
    int t = 0;
    while ((exp_data_q.size() != 0 || exp_stat_q.size() != 0) && t < 5000) begin
      @(posedge clk); t++;
    end
    chk("drain_left", 64'(exp_data_q.size() + exp_stat_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // m_ready driver
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = !m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: handshakes seen at negedge complete at the following rising edge
  logic       stall_pend = 1'b0;
  logic [8:0] stall_val;
  always @(negedge clk) begin
    if (rst) begin
      stall_pend <= 1'b0;
    end else begin
      if (m_valid) begin
        if (stall_pend) chk("m_stall_stable", {m_last, m_data}, stall_val);
        stall_pend <= !m_ready;
        stall_val  <= {m_last, m_data};
        if (m_ready) begin
          if (exp_data_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL m_unexpected actual=%0h expected=none", {m_last, m_data});
          end else chk("m_beat", {m_last, m_data}, exp_data_q.pop_front());
        end
      end else stall_pend <= 1'b0;
      if (chk_valid) begin
        chk("s_ready_in_report", s_ready, 1'b0);
        if (exp_stat_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL chk_unexpected actual=%0h expected=none", {chk_ok, chk_runt, frame_len});
        end else chk("chk_status", {chk_ok, chk_runt, frame_len}, exp_stat_q.pop_front());
      end
    end
  end

  initial begin
    logic [7:0]  f [$];
    logic [31:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 32'(i) << 24;
      repeat (8) v = v[31] ? ((v << 1) ^ 32'h04C1_1DB7) : (v << 1);
      crc_tbl[i] = v;
    end
    s_valid = 1'b0; s_data = 8'd0; s_last = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 8'd0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_chk_valid", chk_valid, 1'b0);
    chk("rst_chk_ok", chk_ok, 1'b0);
    chk("rst_chk_runt", chk_runt, 1'b0);
    chk("rst_frame_len", frame_len, 16'd0);
    chk("rst_s_ready", s_ready, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Known-good single-byte payload, then corrupted FCS, then a runt
    f = {8'h00, 8'hB4, 8'hBF, 8'h08, 8'h4E}; send_frame(f, 1);
    f = {8'h00, 8'hB4, 8'hBF, 8'h08, 8'h4F}; send_frame(f, 1);
    f = {8'h11, 8'h22, 8'h33};               send_frame(f, 1);
    f = {8'hA5};                             send_frame(f, 1);
    f = {8'h01, 8'h02, 8'h03, 8'h04};        send_frame(f, 1);
    drain();

    // Back-to-back good frames with toggling m_ready
    rdy_mode = 1;
    f = {8'h00, 8'hB4, 8'hBF, 8'h08, 8'h4E}; send_frame(f, 1);
    send_frame(f, 1);
    drain();
    rdy_mode = 0;

    // Asynchronous reset mid-frame, then a good frame
    f = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int i = 0; i < 3; i++) send_byte(f[i], 1'b0);
    #2 rst = 1'b1;
    #1 chk("abort_s_ready", s_ready, 1'b0);
    chk("abort_chk_valid", chk_valid, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
`ifdef CRC32_RX_ERRCNT_EN
    err_model = 0;
`endif
    f = {8'h00, 8'hB4, 8'hBF, 8'h08, 8'h4E}; send_frame(f, 1);
    drain();

    // Randomised frames: mixed lengths, good and bad FCS, random back-pressure and gaps
    rdy_mode = 2; gap_pct = 30;
    for (int k = 0; k < 40; k++) begin
      int n = $urandom_range(1, 24);
      if (n >= 5 && $urandom_range(0, 1) == 1) make_good(n - 4, f);
      else begin
        f = {};
        for (int i = 0; i < n; i++) f.push_back(8'($urandom));
      end
      send_frame(f, 1);
    end
    drain();

    // Long frame
    rdy_mode = 0; gap_pct = 0;
    make_good(1000, f);
    send_frame(f, 1);
    drain();

`ifdef CRC32_RX_ERRCNT_EN
    chk("err_cnt", err_cnt, 16'(err_model));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout actual=%0t expected=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
